// File: rtl/intdiv_otf_conv_if.sv
// Handshake bundle for the on-the-fly converter.
//   master : drives start, digit_valid, digit and result_ready (upstream/downstream side)
//   slave  : the converter; drives digit_ready, result, result_valid and busy
interface intdiv_otf_conv_if #(
  parameter int unsigned N = 8
) ();
  logic         start;
  logic         digit_valid;
  logic [1:0]   digit;
  logic         digit_ready;
  logic [N:0]   result;
  logic         result_valid;
  logic         result_ready;
  logic         busy;

  modport master (
    output start, digit_valid, digit, result_ready,
    input  digit_ready, result, result_valid, busy
  );

  modport slave (
    input  start, digit_valid, digit, result_ready,
    output digit_ready, result, result_valid, busy
  );
endinterface

// File: rtl/intdiv_otf_conv.sv
// Digit-serial on-the-fly converter: accumulates an MSD-first SD2 digit stream
// into an (N+1)-bit two's-complement word using Q/QM registers (no carry chain).
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : slave side of intdiv_otf_conv_if
//            start/digit_valid/digit in, digit_ready out,
//            result/result_valid out, result_ready in, busy out
module intdiv_otf_conv #(
  parameter int unsigned N = 8
) (
  input logic             clk,
  input logic             rst_n,
  intdiv_otf_conv_if.slave bus
);

  localparam int unsigned     CntW    = $clog2(N + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  state_e          r_state;
  state_e          w_state_d;
  logic [N:0]      r_q;
  logic [N:0]      w_q_d;
  logic [N:0]      r_qm;
  logic [N:0]      w_qm_d;
  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_q     <= '0;
      r_qm    <= '1;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_q     <= w_q_d;
      r_qm    <= w_qm_d;
      r_cnt   <= w_cnt_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_q_d     = r_q;
    w_qm_d    = r_qm;
    w_cnt_d   = r_cnt;
    // start outranks any digit or result handshake in the same cycle
    if (bus.start) begin
      w_q_d     = '0;
      w_qm_d    = '1;
      w_cnt_d   = '0;
      w_state_d = StAccum;
    end else begin
      unique case (r_state)
        StIdle: ;
        StAccum: begin
          if (bus.digit_valid) begin
            // QM tracks Q-1, so a -1 digit borrows by selecting QM instead of subtracting
            unique case (bus.digit)
              2'b11: begin
                w_q_d  = {r_qm[N-1:0], 1'b1};
                w_qm_d = {r_qm[N-1:0], 1'b0};
              end
              2'b00: begin
                w_q_d  = {r_q[N-1:0], 1'b0};
                w_qm_d = {r_qm[N-1:0], 1'b1};
              end
              default: begin
                w_q_d  = {r_q[N-1:0], 1'b1};
                w_qm_d = {r_q[N-1:0], 1'b0};
              end
            endcase
            w_cnt_d = r_cnt + CntW'(1);
            if (r_cnt == LastCnt) w_state_d = StDone;
          end
        end
        StDone: begin
          if (bus.result_ready) w_state_d = StIdle;
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  // Outputs decode only the state register, so reset clears them asynchronously
  assign bus.digit_ready  = (r_state == StAccum);
  assign bus.result_valid = (r_state == StDone);
  assign bus.busy         = (r_state == StAccum) || (r_state == StDone);
  assign bus.result       = (r_state == StDone) ? r_q : '0;

endmodule
